act_lut_stream: RTL and testbench
=================================

ACT_LUT_STREAM -- requirements
Module: act_lut_stream

Interface
REQ-001 Parameter IN_W, default 4, input sample width, signed two's complement, minimum 2.
REQ-002 Parameter OUT_W, default 7, output sample width, minimum 3.
REQ-003 Port clk  input  1  single clock; all logic on rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port in_valid  input  1  input sample offered.
REQ-006 Port in_ready  output  1  unit accepts the sample this cycle.
REQ-007 Port in_x  input  IN_W  signed sample.
REQ-008 Port in_mode  input  1  0 = tanh, 1 = sigmoid; captured with the sample.
REQ-009 Port out_valid  output  1  result held on out_y.
REQ-010 Port out_ready  input  1  downstream accepts the result.
REQ-011 Port out_y  output  OUT_W  result: signed for tanh, unsigned for sigmoid.
REQ-012 Port cfg_we  input  1  table write strobe.
REQ-013 Port cfg_sel  input  1  table select: 0 = tanh, 1 = sigmoid.
REQ-014 Port cfg_addr  input  IN_W-1  table index (magnitude).
REQ-015 Port cfg_data  input  OUT_W-1  unsigned table entry.

Function
REQ-016 Two tables, each 2^(IN_W-1) entries of OUT_W-1 bits, shall be indexed by |in_x|.
REQ-017 |in_x| of the most-negative input (-2^(IN_W-1)) shall clamp to 2^(IN_W-1)-1.
REQ-018 Tanh mode: x>=0 -> out_y = T0[|x|] zero-extended; x<0 -> out_y = -T0[|x|] (odd symmetry).
REQ-019 Sigmoid mode: x>=0 -> out_y = T1[|x|]; x<0 -> out_y = 2^(OUT_W-1) - T1[|x|]. Computed in OUT_W bits, no saturation.
REQ-020 Pipeline shall have two stages: S1 registers sign, clamped magnitude and mode; S2 performs the table read, applies symmetry and registers out_y.
REQ-021 Latency from accepted input (in_valid&in_ready) to out_valid shall be exactly 2 cycles with no stall.
REQ-022 Pipeline enable en = ~out_valid | out_ready; in_ready = en; all stages advance only when en=1.
REQ-023 Throughput shall be one sample per cycle while out_ready=1.
REQ-024 While out_valid=1 and out_ready=0, out_y and out_valid shall hold stable and no stage shall advance.
REQ-025 Mode shall travel with each sample; mixed tanh/sigmoid streams shall produce per-sample correct results.
REQ-026 cfg_we shall write cfg_data to the table selected by cfg_sel at cfg_addr on the clock edge, at any time, independent of en.
REQ-027 A lookup of the same table/address in the same cycle as a write shall return the pre-write value.
REQ-028 in_valid=0 with en=1 shall insert a bubble; S1/S2 valid bits shall carry the bubble.

Reset
REQ-029 rst_n low shall immediately clear S1 valid, S2 valid and out_valid to 0, and out_y to 0.
REQ-030 Table contents shall not be reset; they shall be reloaded by cfg writes after power-up.
REQ-031 Reset mid-stream shall discard all in-flight samples; no partial result shall appear after release.
REQ-032 in_ready shall read 1 during and after reset.

Configuration
REQ-033 Macro ACT_LUT_CNT_EN defined: output port out_cnt (32 bits) shall count out_valid&out_ready handshakes, wrap from 0xFFFFFFFF to 0, and reset to 0.
REQ-034 Macro ACT_LUT_CNT_EN undefined: out_cnt and its counter shall be absent; all other behaviour shall be identical.

Verification (IN_W=4, OUT_W=7)
REQ-035 T0[3]=46; in_x=3, mode 0, out_ready=1 -> out_y=46 (7'h2E) exactly 2 cycles later.
REQ-036 T0[3]=46; in_x=4'hD (-3), mode 0 -> out_y=7'h52 (-46).
REQ-037 T0[7]=60; in_x=4'h8 (-8), mode 0 -> magnitude clamps to 7, out_y=-60 (7'h44).
REQ-038 T1[2]=44; in_x=4'hE (-2), mode 1 -> out_y=20; in_x=2, mode 1 -> out_y=44.
REQ-039 Stream of 4 samples; out_ready=0 for 3 cycles when first result is valid -> out_y stable, in_ready=0; after release all 4 results in order, no loss or duplication.
REQ-040 rst_n pulsed low with 2 samples in flight -> out_valid=0 immediately; no result after release; with ACT_LUT_CNT_EN, out_cnt=0.

Source files
------------

// File: rtl/act_lut_stream.sv
// ---------------------------------------------------------------------------
// act_lut_stream
//   Streaming activation-function unit built on two run-time loadable
//   lookup tables (tanh and sigmoid). Each table holds the function value
//   for non-negative magnitudes. Negative inputs reuse the same entries
//   through symmetry:
//     tanh    : f(-x) = -f(x)
//     sigmoid : f(-x) = 2^(OUT_W-1) - f(x)
//
//   Pipeline (en = ~out_valid | out_ready, in_ready = en):
//     S1 - registers sign, clamped magnitude and mode of the accepted sample
//     S2 - table read, symmetry fix-up, registers out_y / out_valid
//
//   Optional feature (compile-time macro ACT_LUT_CNT_EN):
//     adds 32-bit output out_cnt counting out_valid & out_ready handshakes.
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   input sample offered
//   in_ready   out  sample accepted this cycle
//   in_x       in   [IN_W-1:0]  signed sample
//   in_mode    in   0 = tanh, 1 = sigmoid
//   out_valid  out  result held on out_y
//   out_ready  in   downstream accepts the result
//   out_y      out  [OUT_W-1:0] result (signed tanh / unsigned sigmoid)
//   cfg_we     in   table write strobe
//   cfg_sel    in   0 = tanh table, 1 = sigmoid table
//   cfg_addr   in   [IN_W-2:0]  table index (magnitude)
//   cfg_data   in   [OUT_W-2:0] table entry
//   out_cnt    out  [31:0] handshake counter (ACT_LUT_CNT_EN only)
// ---------------------------------------------------------------------------
module act_lut_stream #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_x,
    input  logic              in_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_y,
    input  logic              cfg_we,
    input  logic              cfg_sel,
    input  logic [IN_W-2:0]   cfg_addr,
    input  logic [OUT_W-2:0]  cfg_data
`ifdef ACT_LUT_CNT_EN
    ,
    output logic [31:0]       out_cnt
`endif
);

    localparam int DEPTH = 1 << (IN_W - 1);
    localparam logic [OUT_W-1:0] C_HALF = {1'b1, {(OUT_W-1){1'b0}}};

    // Lookup tables: deliberately not reset, contents come from cfg writes.
    logic [OUT_W-2:0] r_tab_tanh [DEPTH];
    logic [OUT_W-2:0] r_tab_sig  [DEPTH];

    logic             w_en;
    logic             w_neg;
    logic [IN_W-1:0]  w_abs;
    logic [IN_W-2:0]  w_mag;

    logic             r_s1_valid;
    logic             r_s1_neg;
    logic             r_s1_mode;
    logic [IN_W-2:0]  r_s1_mag;

    logic [OUT_W-2:0] w_t_tanh;
    logic [OUT_W-2:0] w_t_sig;
    logic [OUT_W-1:0] w_pos;
    logic [OUT_W-1:0] w_y;

    logic             r_out_valid;
    logic [OUT_W-1:0] r_out_y;

    assign w_en      = ~r_out_valid | out_ready;
    assign in_ready  = w_en;
    assign out_valid = r_out_valid;
    assign out_y     = r_out_y;

    // ---------------- table writes (independent of pipeline enable) -------
    always_ff @(posedge clk) begin
        if (cfg_we) begin
            if (cfg_sel) begin
                r_tab_sig[cfg_addr]  <= cfg_data;
            end else begin
                r_tab_tanh[cfg_addr] <= cfg_data;
            end
        end
    end

    // ---------------- S1: sign / magnitude extraction ---------------------
    assign w_neg = in_x[IN_W-1];
    assign w_abs = w_neg ? (IN_W'(0) - in_x) : in_x;
    // Only the most-negative input leaves the MSB set after negation;
    // it saturates to the largest table index.
    assign w_mag = w_abs[IN_W-1] ? {(IN_W-1){1'b1}} : w_abs[IN_W-2:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_neg   <= 1'b0;
            r_s1_mode  <= 1'b0;
            r_s1_mag   <= '0;
        end else if (w_en) begin
            r_s1_valid <= in_valid;
            r_s1_neg   <= w_neg;
            r_s1_mode  <= in_mode;
            r_s1_mag   <= w_mag;
        end
    end

    // ---------------- S2: lookup and symmetry -----------------------------
    // Combinational read of the table registers: a write on the same edge
    // has not landed yet, so a same-cycle lookup sees the old entry.
    assign w_t_tanh = r_tab_tanh[r_s1_mag];
    assign w_t_sig  = r_tab_sig[r_s1_mag];
    assign w_pos    = {1'b0, (r_s1_mode ? w_t_sig : w_t_tanh)};

    always_comb begin
        w_y = w_pos;
        if (r_s1_neg) begin
            // Both branches wrap modulo 2^OUT_W; no saturation intended.
            w_y = r_s1_mode ? (C_HALF - w_pos) : (OUT_W'(0) - w_pos);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_y     <= '0;
        end else if (w_en) begin
            r_out_valid <= r_s1_valid;
            // Bubbles leave the last result in place.
            if (r_s1_valid) begin
                r_out_y <= w_y;
            end
        end
    end

`ifdef ACT_LUT_CNT_EN
    logic [31:0] r_out_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_cnt <= '0;
        end else if (r_out_valid && out_ready) begin
            r_out_cnt <= r_out_cnt + 32'd1;
        end
    end

    assign out_cnt = r_out_cnt;
`endif

endmodule

// File: tb/tb_act_lut_stream.sv
module tb_act_lut_stream;

    localparam int IN_W   = 4;
    localparam int OUT_W  = 7;
    localparam int DEPTH  = 1 << (IN_W - 1);
    localparam int MAXMAG = DEPTH - 1;
    localparam int HALF   = 1 << (OUT_W - 1);

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [IN_W-1:0]   in_x;
    logic              in_mode;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_y;
    logic              cfg_we;
    logic              cfg_sel;
    logic [IN_W-2:0]   cfg_addr;
    logic [OUT_W-2:0]  cfg_data;
`ifdef ACT_LUT_CNT_EN
    logic [31:0]       out_cnt;
`endif

    int total = 0;
    int bad   = 0;

    // reference tables
    int m_t0 [DEPTH];
    int m_t1 [DEPTH];

    act_lut_stream #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .cfg_we    (cfg_we),
        .cfg_sel   (cfg_sel),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data)
`ifdef ACT_LUT_CNT_EN
        ,
        .out_cnt   (out_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Mathematical reference: value from |x| (clamped) plus symmetry rule.
    function automatic logic [OUT_W-1:0] ref_y(input logic [IN_W-1:0] x, input logic mode);
        int v;
        int mag;
        int t;
        int r;
        v   = int'($signed(x));
        mag = (v < 0) ? -v : v;
        if (mag > MAXMAG) mag = MAXMAG;
        t = mode ? m_t1[mag] : m_t0[mag];
        if (v >= 0)    r = t;
        else if (mode) r = HALF - t;
        else           r = -t;
        r = r & ((1 << OUT_W) - 1);
        return r[OUT_W-1:0];
    endfunction

    task automatic cfg_write(input logic sel, input int addr, input int data);
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_sel  = sel;
        cfg_addr = addr[IN_W-2:0];
        cfg_data = data[OUT_W-2:0];
        @(negedge clk);
        cfg_we = 1'b0;
        if (sel) m_t1[addr] = data;
        else     m_t0[addr] = data;
    endtask

    // One isolated sample; returns out_valid one and two cycles later.
    task automatic single(input logic [IN_W-1:0] x, input logic mode,
                          output logic v1, output logic v2, output logic [OUT_W-1:0] y);
        @(negedge clk);
        in_valid  = 1'b1;
        in_x      = x;
        in_mode   = mode;
        out_ready = 1'b1;
        @(negedge clk);
        v1 = out_valid;
        in_valid = 1'b0;
        @(negedge clk);
        v2 = out_valid;
        y  = out_y;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_x      = '0;
        in_mode   = 1'b0;
        out_ready = 1'b1;
        cfg_we    = 1'b0;
        cfg_sel   = 1'b0;
        cfg_addr  = '0;
        cfg_data  = '0;
        repeat (2) @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++;
        if (out_y !== '0) begin bad++; $display("FAIL reset_out_y got=%h want=0", out_y); end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("FAIL post_reset in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
        $display("reset: in_ready=%b out_valid=%b out_y=%h", in_ready, out_valid, out_y);
    endtask

    task automatic load_tables();
        for (int i = 0; i < DEPTH; i++) begin
            cfg_write(1'b0, i, int'($urandom_range(0, HALF - 1)));
            cfg_write(1'b1, i, int'($urandom_range(0, HALF - 1)));
        end
        cfg_write(1'b0, 3, 46);
        cfg_write(1'b0, 7, 60);
        cfg_write(1'b1, 2, 44);
    endtask

    task automatic test_directed();
        logic [IN_W-1:0]  xs [5];
        logic             ms [5];
        logic [OUT_W-1:0] ws [5];
        logic v1, v2;
        logic [OUT_W-1:0] y;
        xs[0] = 4'h3; ms[0] = 1'b0; ws[0] = 7'h2E;
        xs[1] = 4'hD; ms[1] = 1'b0; ws[1] = 7'h52;
        xs[2] = 4'h8; ms[2] = 1'b0; ws[2] = 7'h44;
        xs[3] = 4'hE; ms[3] = 1'b1; ws[3] = 7'd20;
        xs[4] = 4'h2; ms[4] = 1'b1; ws[4] = 7'd44;
        for (int i = 0; i < 5; i++) begin
            single(xs[i], ms[i], v1, v2, y);
            total++;
            if (v1 !== 1'b0 || v2 !== 1'b1) begin
                bad++; $display("FAIL latency x=%h mode=%b valid@1=%b valid@2=%b want 0/1", xs[i], ms[i], v1, v2);
            end
            total++;
            if (y !== ws[i]) begin
                bad++; $display("FAIL directed x=%h mode=%b got=%h want=%h", xs[i], ms[i], y, ws[i]);
            end
            $display("directed: x=%h mode=%b y=%h", xs[i], ms[i], y);
        end
    endtask

    task automatic test_read_during_write();
        logic v1, v2;
        logic [OUT_W-1:0] y;
        logic [OUT_W-1:0] old_v;
        old_v = ref_y(4'h5, 1'b0);
        @(negedge clk);
        in_valid = 1'b1; in_x = 4'h5; in_mode = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        // sample sits in S1 now: write the very entry it reads
        in_valid = 1'b0;
        cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = 3'd5; cfg_data = 6'd9;
        @(negedge clk);
        cfg_we = 1'b0;
        total++;
        if (out_valid !== 1'b1 || out_y !== old_v) begin
            bad++; $display("FAIL rdw_old got=%h/%b want=%h/1", out_y, out_valid, old_v);
        end
        $display("rdw: same-cycle lookup y=%h", out_y);
        m_t0[5] = 9;
        single(4'h5, 1'b0, v1, v2, y);
        total++;
        if (y !== 7'd9) begin bad++; $display("FAIL rdw_new got=%h want=09", y); end
        $display("rdw: later lookup y=%h", y);
    endtask

    task automatic test_stall();
        logic [IN_W-1:0] sx [4];
        logic            sm [4];
        logic [OUT_W-1:0] exp_q [$];
        logic [OUT_W-1:0] want;
        logic ov, prev_hold;
        logic [OUT_W-1:0] oy, prev_y;
        int si, got, stall_left;
        bit first_seen;
        for (int i = 0; i < 4; i++) begin
            sx[i] = IN_W'($urandom);
            sm[i] = 1'($urandom);
        end
        si = 0; got = 0; stall_left = 0; first_seen = 0;
        prev_hold = 1'b0; prev_y = '0;
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            @(negedge clk);
            ov = out_valid; oy = out_y;
            if (prev_hold) begin
                total++;
                if (ov !== 1'b1 || oy !== prev_y) begin
                    bad++; $display("FAIL stall_hold got=%h/%b want=%h/1", oy, ov, prev_y);
                end
            end
            if (ov && !first_seen) begin first_seen = 1; stall_left = 3; end
            if (stall_left > 0) begin out_ready = 1'b0; stall_left--; end
            else out_ready = 1'b1;
            in_valid = (si < 4);
            if (si < 4) begin in_x = sx[si]; in_mode = sm[si]; end
            #1;
            if (!out_ready && ov) begin
                total++;
                if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready got=%b want=0", in_ready); end
            end
            if (ov && out_ready) begin
                want = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                total++;
                if (oy !== want) begin bad++; $display("FAIL stall_data got=%h want=%h", oy, want); end
                $display("stall: result %0d y=%h", got, oy);
                got++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_y(in_x, in_mode));
                si++;
            end
            prev_hold = ov && !out_ready;
            prev_y = oy;
        end
        in_valid = 1'b0;
        total++;
        if (got != 4) begin bad++; $display("FAIL stall_count got=%0d want=4", got); end
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_dup out_valid=%b want=0", out_valid); end
    endtask

    task automatic test_random();
        logic [OUT_W-1:0] exp_q [$];
        logic [OUT_W-1:0] want;
        logic ov, prev_hold;
        logic [OUT_W-1:0] oy, prev_y;
        int n_in, n_out;
        bit draining;
        prev_hold = 1'b0; prev_y = '0; n_in = 0; n_out = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            draining = (cyc >= 300);
            if (draining && exp_q.size() == 0 && out_valid === 1'b0) break;
            @(negedge clk);
            ov = out_valid; oy = out_y;
            if (prev_hold) begin
                total++;
                if (ov !== 1'b1 || oy !== prev_y) begin
                    bad++; $display("FAIL rand_hold got=%h/%b want=%h/1", oy, ov, prev_y);
                end
            end
            out_ready = draining ? 1'b1 : ($urandom_range(0, 9) < 7);
            in_valid  = draining ? 1'b0 : ($urandom_range(0, 3) != 0);
            in_x      = IN_W'($urandom);
            in_mode   = 1'($urandom);
            #1;
            total++;
            if (in_ready !== (!ov || out_ready)) begin
                bad++; $display("FAIL rand_in_ready got=%b want=%b", in_ready, (!ov || out_ready));
            end
            if (ov && out_ready) begin
                want = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                total++;
                if (oy !== want) begin bad++; $display("FAIL rand_data n=%0d got=%h want=%h", n_out, oy, want); end
                n_out++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_y(in_x, in_mode));
                n_in++;
            end
            prev_hold = ov && !out_ready;
            prev_y = oy;
        end
        in_valid = 1'b0;
        total++;
        if (exp_q.size() != 0 || n_in != n_out) begin
            bad++; $display("FAIL rand_drain in=%0d out=%0d pending=%0d want 0", n_in, n_out, exp_q.size());
        end
        $display("random: accepted=%0d delivered=%0d", n_in, n_out);
    endtask

    task automatic test_reset_midstream();
        @(negedge clk);
        out_ready = 1'b1;
        in_valid = 1'b1; in_x = 4'h1; in_mode = 1'b0;
        @(negedge clk);
        in_x = 4'h6; in_mode = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL midrst_pre out_valid=%b want=1", out_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || out_y !== '0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL midrst_clear out_valid=%b out_y=%h in_ready=%b want 0/00/1", out_valid, out_y, in_ready);
        end
`ifdef ACT_LUT_CNT_EN
        total++;
        if (out_cnt !== 32'd0) begin bad++; $display("FAIL midrst_cnt got=%0d want=0", out_cnt); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_ghost cycle=%0d out_valid=%b want=0", i, out_valid); end
        end
        $display("midstream reset: out_valid=%b after release", out_valid);
    endtask

    initial begin
        test_reset();
        load_tables();
        test_directed();
        test_read_during_write();
        test_stall();
        test_random();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
